// File: rtl/i2s_adc_rx.sv
`timescale 1ns/1ps
// i2s_adc_rx: receives the codec ADC serial stream (codec is bit/frame clock
// master) and turns each LRCK frame into one {left, right} pair. Pairs are
// buffered in a small FIFO and handed out on a valid/ready stream.
//
// Ports:
//   clk, reset          system clock (>= 4x bclk), synchronous active-high reset
//   enable              receiver enable; low forces frame re-synchronisation
//   bclk, adclrck,      codec bit clock, frame clock (low = left slot) and
//   adcdat              serial data, MSB first; all asynchronous to clk
//   out_data            {left, right} at the FIFO head
//   out_valid/out_ready stream handshake, transfer when both are high
//   overflow            sticky: a finished frame was dropped on a full FIFO
//   clr_overflow        single-cycle pulse clearing overflow (a new overflow wins)
//
// Build option: define I2S_ADC_RX_LEFT_JUSTIFIED_EN for left-justified
// alignment (MSB on the LRCK edge). Default is I2S one-bit-delay alignment.
module i2s_adc_rx #(
  parameter int DATA_WIDTH = 24,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    enable,
  input  logic                    bclk,
  input  logic                    adclrck,
  input  logic                    adcdat,
  output logic [2*DATA_WIDTH-1:0] out_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic                    overflow,
  input  logic                    clr_overflow
);

  localparam int CW = $clog2(DATA_WIDTH + 1);
  localparam int AW = $clog2(FIFO_DEPTH);
`ifdef I2S_ADC_RX_LEFT_JUSTIFIED_EN
  localparam bit LEFT_JUST = 1'b1;
`else
  localparam bit LEFT_JUST = 1'b0;
`endif
  localparam logic [CW-1:0] CNT_FULL  = CW'(DATA_WIDTH);
  localparam logic [CW-1:0] CNT_START = LEFT_JUST ? CW'(1) : CW'(0);

  typedef enum logic [1:0] {ST_SYNC, ST_LEFT, ST_RIGHT} state_t;

  // Writes bit b at MSB-relative position cnt; positions past the word are ignored,
  // so long slots drop their tail and short slots leave zero LSBs.
  function automatic logic [DATA_WIDTH-1:0] place_bit(input logic [DATA_WIDTH-1:0] word,
                                                      input logic [CW-1:0] cnt,
                                                      input logic b);
    logic [DATA_WIDTH-1:0] r;
    r = word;
    for (int i = 0; i < DATA_WIDTH; i++)
      if (int'(cnt) == DATA_WIDTH - 1 - i) r[i] = b;
    return r;
  endfunction

  logic bclk_p0, bclk_p1, bclk_p2;
  logic lrck_p0, lrck_p1, lrck_p2;
  logic dat_p0, dat_p1, dat_p2;
  logic vld_p2;
  logic lrck_prev;
  logic fall, rise;
  state_t state, state_nx;
  logic start_left, start_right, left_bit, right_bit, push_req;
  logic [CW-1:0] cnt;
  logic [DATA_WIDTH-1:0] left_word, right_word;
  logic [2*DATA_WIDTH-1:0] pair_p3;
  logic vld_p3;
  logic [2*DATA_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [AW:0] wr_ptr, rd_ptr;
  logic empty, full, pop, push_ok;

  // Stage p0/p1: two-flop synchronizers; stage p2: bclk rising-edge tick (vld_p2)
  always_ff @(posedge clk) begin
    if (reset) begin
      bclk_p0 <= 1'b0; bclk_p1 <= 1'b0; bclk_p2 <= 1'b0;
      lrck_p0 <= 1'b0; lrck_p1 <= 1'b0; lrck_p2 <= 1'b0;
      dat_p0  <= 1'b0; dat_p1  <= 1'b0; dat_p2  <= 1'b0;
      vld_p2  <= 1'b0;
    end else begin
      bclk_p0 <= bclk;    bclk_p1 <= bclk_p0;    bclk_p2 <= bclk_p1;
      lrck_p0 <= adclrck; lrck_p1 <= lrck_p0;    lrck_p2 <= lrck_p1;
      dat_p0  <= adcdat;  dat_p1  <= dat_p0;     dat_p2  <= dat_p1;
      vld_p2  <= bclk_p1 & ~bclk_p2;
    end
  end

  // LRCK history advances on every tick, even while disabled, so that a
  // re-enable in the middle of a slot never sees a spurious edge.
  always_ff @(posedge clk) begin
    if (reset)       lrck_prev <= 1'b0;
    else if (vld_p2) lrck_prev <= lrck_p2;
  end

  assign fall = vld_p2 & lrck_prev & ~lrck_p2;
  assign rise = vld_p2 & ~lrck_prev & lrck_p2;

  always_ff @(posedge clk) begin
    if (reset) state <= ST_SYNC;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    if (!enable) begin
      state_nx = ST_SYNC;
    end else begin
      case (state)
        ST_SYNC:  if (fall) state_nx = ST_LEFT;
        ST_LEFT:  if (rise) state_nx = ST_RIGHT;
        ST_RIGHT: if (fall) state_nx = ST_LEFT;
        default:  state_nx = ST_SYNC;
      endcase
    end
  end

  // In I2S alignment the bit seen on an edge tick is the last bit of the slot
  // that just ended; it is kept only if that word still has room.
  always_comb begin
    start_left  = 1'b0;
    start_right = 1'b0;
    left_bit    = 1'b0;
    right_bit   = 1'b0;
    push_req    = 1'b0;
    if (enable && vld_p2) begin
      case (state)
        ST_SYNC: start_left = fall;
        ST_LEFT: begin
          if (rise) begin
            start_right = 1'b1;
            left_bit    = !LEFT_JUST;
          end else begin
            left_bit = 1'b1;
          end
        end
        ST_RIGHT: begin
          if (fall) begin
            start_left = 1'b1;
            push_req   = 1'b1;
            right_bit  = !LEFT_JUST;
          end else begin
            right_bit = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Stage p3: slot assembly and completed-pair register (vld_p3 = push)
  always_ff @(posedge clk) begin
    if (start_left)
      left_word <= LEFT_JUST ? place_bit('0, '0, dat_p2) : '0;
    else if (left_bit)
      left_word <= place_bit(left_word, cnt, dat_p2);
    if (start_right)
      right_word <= LEFT_JUST ? place_bit('0, '0, dat_p2) : '0;
    else if (right_bit)
      right_word <= place_bit(right_word, cnt, dat_p2);
    if (push_req)
      pair_p3 <= {left_word, LEFT_JUST ? right_word : place_bit(right_word, cnt, dat_p2)};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt    <= '0;
      vld_p3 <= 1'b0;
    end else begin
      vld_p3 <= push_req;
      if (start_left || start_right)
        cnt <= CNT_START;
      else if ((left_bit || right_bit) && cnt != CNT_FULL)
        cnt <= cnt + CW'(1);
    end
  end

  // Stage p4: pair FIFO; a pop in the same cycle frees the slot a full push needs
  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign pop     = out_valid && out_ready;
  assign push_ok = vld_p3 && (!full || pop);

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr[AW-1:0]] <= pair_p3;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      overflow <= 1'b0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop)     rd_ptr <= rd_ptr + 1'b1;
      if (vld_p3 && full && !pop) overflow <= 1'b1;
      else if (clr_overflow)      overflow <= 1'b0;
    end
  end

  assign out_valid = !empty;
  assign out_data  = empty ? '0 : mem[rd_ptr[AW-1:0]];

endmodule
